and44_sweep_checker: RTL and testbench

AND44_SWEEP_CHECKER -- requirements
Module: and44_sweep_checker

---
 rtl/and44_sweep_checker.sv | 199 +++++++++++++++++++
 tb/tb_and44_sweep_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/and44_sweep_checker.sv
// ---------------------------------------------------------------------------
// and44_sweep_checker
//
// Exhaustive self-test sequencer for a 4-input / 9-output AND stage. A start
// pulse steps the 4-bit stimulus through all 16 input vectors. Each vector
// takes SETTLE_CYCLES+2 clock cycles:
//   DRIVE   - one cycle with the vector already on dut_in
//   SETTLE  - SETTLE_CYCLES cycles for the response to propagate
//   COMPARE - one cycle where dut_out is checked against the expected response
// Mismatching vectors are counted once each. The first failing vector index
// is captured. After vector 15 the block sits in DONE with the verdict frozen.
//
// Parameters
//   SETTLE_CYCLES  wait cycles between driving and sampling (0..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       pulse: begin a sweep (ignored while busy)
//   abort       synchronous cancel of a running sweep (ignored when idle/done)
//   dut_out     response of the AND stage, bit0 = n7 ... bit8 = n15
//   dut_in      stimulus, bit0 = in1 ... bit3 = in4
//   busy        high in DRIVE, SETTLE and COMPARE
//   done        high from sweep completion until the next start or reset
//   pass        valid with done; 1 when no vector mismatched
//   err_count   number of mismatching vectors (0..16)
//   first_fail  index of the first mismatching vector
//   fail_seen   qualifies first_fail
// ---------------------------------------------------------------------------
module and44_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [8:0] dut_out,
  output logic [3:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_seen
);

  // The settle counter is loaded with SETTLE_CYCLES-1 and leaves SETTLE when
  // it reads zero, giving exactly SETTLE_CYCLES cycles in that state. With
  // SETTLE_CYCLES=0 the SETTLE state is skipped entirely.
  localparam logic [3:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_VEC = 4'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] vec_q;
  logic [3:0] settle_cnt_q;
  logic [3:0] dut_in_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_count_q;
  logic [3:0] first_fail_q;
  logic       fail_seen_q;

  logic [8:0] golden_w;
  logic       mismatch_w;
  logic [4:0] err_count_d;

  // Expected response of a correct AND stage for stimulus v.
  function automatic logic [8:0] golden(input logic [3:0] v);
    logic in1, in2, in3, in4, a, b;
    logic [8:0] r;
    in1 = v[0];
    in2 = v[1];
    in3 = v[2];
    in4 = v[3];
    a   = in1 & in2;
    b   = in3 & in4;
    r[0] = a & b;      // n7
    r[1] = a & in3;    // n8
    r[2] = a & in4;    // n9
    r[3] = b & in1;    // n10
    r[4] = b & in2;    // n11
    r[5] = in1 & in3;  // n12
    r[6] = in1 & in4;  // n13
    r[7] = in2 & in3;  // n14
    r[8] = in2 & in4;  // n15
    return r;
  endfunction

  // A vector counts as one error no matter how many of its bits differ.
  always_comb begin
    golden_w    = golden(vec_q);
    mismatch_w  = (dut_out != golden_w);
    err_count_d = err_count_q + (mismatch_w ? 5'd1 : 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= 4'd0;
      settle_cnt_q <= 4'd0;
      dut_in_q     <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 5'd0;
      first_fail_q <= 4'd0;
      fail_seen_q  <= 1'b0;
    end else if (busy_q && abort) begin
      // Abort wins over a COMPARE in the same cycle: the counters keep what
      // they had and the stimulus is parked at zero.
      state_q      <= IDLE;
      vec_q        <= 4'd0;
      settle_cnt_q <= 4'd0;
      dut_in_q     <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            vec_q        <= 4'd0;
            dut_in_q     <= 4'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 5'd0;
            first_fail_q <= 4'd0;
            fail_seen_q  <= 1'b0;
          end
        end

        // dut_in is loaded with the vector on entry to DRIVE, so it is stable
        // for the whole DRIVE/SETTLE/COMPARE window of that vector.
        DRIVE: begin
          if (SETTLE_CYCLES == 0) begin
            state_q <= COMPARE;
          end else begin
            state_q      <= SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
          end
        end

        SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            state_q <= COMPARE;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end

        COMPARE: begin
          err_count_q <= err_count_d;
          if (mismatch_w && !fail_seen_q) begin
            first_fail_q <= vec_q;
            fail_seen_q  <= 1'b1;
          end
          if (vec_q == LAST_VEC) begin
            // vec and dut_in stay at 15 so the final stimulus is visible.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == 5'd0);
          end else begin
            state_q  <= DRIVE;
            vec_q    <= vec_q + 4'd1;
            dut_in_q <= vec_q + 4'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_and44_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_and44_sweep_checker
//
// Three checkers (SETTLE_CYCLES = 1, 0, 3) share start/abort/rst. Each one
// drives its own copy of an AND-stage model whose fault can be selected:
// none, n7 stuck at 0, n12 = in1|in3, or a random per-vector bit-flip table.
// A reference model describes the sweep by elapsed-cycle arithmetic
// (vector = t / period, compare on the last cycle of a period). It is
// compared with every checker on each falling edge. Directed sweeps pin
// literal results, then a randomized phase exercises start/abort/reset/fault
// interactions.
// ---------------------------------------------------------------------------
module tb_and44_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] fault_mode = 2'd0;
  logic [8:0] mask [16];

  logic [8:0] dout_w [3];
  logic [3:0] din_w  [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [4:0] err_w  [3];
  logic [3:0] ff_w   [3];
  logic       fs_w   [3];

  int vectors = 0;
  int miscompares = 0;

  // Reference behaviour of a correct AND stage, bit0 = n7 .. bit8 = n15.
  function automatic logic [8:0] gold(input logic [3:0] v);
    logic i1, i2, i3, i4;
    i1 = v[0]; i2 = v[1]; i3 = v[2]; i4 = v[3];
    return {i2 & i4, i2 & i3, i1 & i4, i1 & i3,
            i2 & i3 & i4, i1 & i3 & i4, i1 & i2 & i4, i1 & i2 & i3,
            i1 & i2 & i3 & i4};
  endfunction

  function automatic logic [8:0] fault_out(input logic [3:0] v, input logic [1:0] mode,
                                           input logic [8:0] m);
    logic [8:0] g;
    g = gold(v);
    case (mode)
      2'd1:    g[0] = 1'b0;
      2'd2:    g[5] = v[0] | v[2];
      2'd3:    g = g ^ m;
      default: ;
    endcase
    return g;
  endfunction

  function automatic int per(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 5;
  endfunction

  function automatic bit vec_bad(input int v);
    return fault_out(4'(v), fault_mode, mask[v]) != gold(4'(v));
  endfunction

  assign dout_w[0] = fault_out(din_w[0], fault_mode, mask[din_w[0]]);
  assign dout_w[1] = fault_out(din_w[1], fault_mode, mask[din_w[1]]);
  assign dout_w[2] = fault_out(din_w[2], fault_mode, mask[din_w[2]]);

  and44_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout_w[0]),
    .dut_in(din_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_fail(ff_w[0]), .fail_seen(fs_w[0]));

  and44_sweep_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout_w[1]),
    .dut_in(din_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_fail(ff_w[1]), .fail_seen(fs_w[1]));

  and44_sweep_checker #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout_w[2]),
    .dut_in(din_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err_w[2]), .first_fail(ff_w[2]), .fail_seen(fs_w[2]));

  task automatic chk(input string nm, input int u, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s u%0d: got %0h, expected %0h at %0t", nm, u, act, exp, $time);
    end
  endtask

  // Reference model state: running flag, cycles elapsed in sweep, results.
  bit m_run [3];
  int m_t   [3];
  int m_err [3];
  int m_ff  [3];
  bit m_fs  [3];
  bit m_done[3];
  bit m_pass[3];
  int m_din [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_run[i] <= 0; m_t[i] <= 0; m_err[i] <= 0; m_ff[i] <= 0;
        m_fs[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0; m_din[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_run[i]) begin
          if (start) begin
            m_run[i] <= 1; m_t[i] <= 0; m_err[i] <= 0; m_ff[i] <= 0;
            m_fs[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0;
          end
        end else if (abort) begin
          m_run[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0; m_din[i] <= 0;
        end else if (m_t[i] % per(i) == per(i) - 1) begin
          int v;
          int e;
          v = m_t[i] / per(i);
          e = m_err[i] + (vec_bad(v) ? 1 : 0);
          m_err[i] <= e;
          if (vec_bad(v) && !m_fs[i]) begin
            m_fs[i] <= 1; m_ff[i] <= v;
          end
          if (v == 15) begin
            m_run[i] <= 0; m_done[i] <= 1; m_pass[i] <= (e == 0); m_din[i] <= 15;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, 32'(busy_w[i]), 32'(m_run[i]));
      chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
      if (m_done[i]) chk("pass", i, 32'(pass_w[i]), 32'(m_pass[i]));
      chk("err_count", i, 32'(err_w[i]), m_err[i]);
      chk("first_fail", i, 32'(ff_w[i]), m_ff[i]);
      chk("fail_seen", i, 32'(fs_w[i]), 32'(m_fs[i]));
      chk("dut_in", i, 32'(din_w[i]), m_run[i] ? m_t[i] / per(i) : m_din[i]);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_din"}, i, 32'(din_w[i]), 0);
      chk({nm, "_busy"}, i, 32'(busy_w[i]), 0);
      chk({nm, "_done"}, i, 32'(done_w[i]), 0);
      chk({nm, "_pass"}, i, 32'(pass_w[i]), 0);
      chk({nm, "_err"}, i, 32'(err_w[i]), 0);
      chk({nm, "_ff"}, i, 32'(ff_w[i]), 0);
      chk({nm, "_fs"}, i, 32'(fs_w[i]), 0);
    end
  endtask

  // Full sweep: latency from the start edge to done is 16*(SETTLE_CYCLES+2).
  task automatic run_sweep();
    int dc [3];
    for (int i = 0; i < 3; i++) dc[i] = -1;
    pulse_start();
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (dc[i] < 0 && done_w[i]) dc[i] = c;
      if (c < 32 && c % 8 == 1) chk("step0_din", 1, 32'(din_w[1]), c / 2);
      if (dc[0] >= 0 && dc[1] >= 0 && dc[2] >= 0) break;
    end
    for (int i = 0; i < 3; i++) chk("latency", i, dc[i], 16 * per(i));
  endtask

  task automatic check_result(input string nm, input int e, input int ff,
                              input bit p, input bit fs);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_err"}, i, 32'(err_w[i]), e);
      chk({nm, "_ff"}, i, 32'(ff_w[i]), ff);
      chk({nm, "_pass"}, i, 32'(pass_w[i]), 32'(p));
      chk({nm, "_fs"}, i, 32'(fs_w[i]), 32'(fs));
      chk({nm, "_din"}, i, 32'(din_w[i]), 15);
    end
  endtask

  initial begin
    for (int v = 0; v < 16; v++) mask[v] = 9'd0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 for (int i = 0; i < 3; i++) chk("idle_after_rst", i, 32'(busy_w[i]), 0);

    fault_mode = 2'd0;
    run_sweep();
    check_result("good", 0, 0, 1'b1, 1'b0);

    fault_mode = 2'd1;
    run_sweep();
    check_result("n7_stuck0", 1, 15, 1'b0, 1'b1);

    fault_mode = 2'd2;
    run_sweep();
    check_result("n12_or", 8, 1, 1'b0, 1'b1);

    // Abort lands on the COMPARE of vector 5 of the SETTLE_CYCLES=1 checker.
    pulse_start();
    repeat (17) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    chk("abort_busy", 0, 32'(busy_w[0]), 0);
    chk("abort_done", 0, 32'(done_w[0]), 0);
    chk("abort_din", 0, 32'(din_w[0]), 0);
    chk("abort_err", 0, 32'(err_w[0]), 3);
    chk("abort_ff", 0, 32'(ff_w[0]), 1);

    // Start and abort together while idle behave as start.
    repeat (2) @(posedge clk);
    #2 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #2 begin start = 1'b0; abort = 1'b0; end
    for (int i = 0; i < 3; i++) chk("start_abort_idle", i, 32'(busy_w[i]), 1);

    // Asynchronous reset mid-sweep, then a fresh clean sweep.
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    fault_mode = 2'd0;
    run_sweep();
    check_result("after_rst", 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 24) == 0);
      abort = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) begin
        fault_mode = 2'($urandom_range(0, 3));
        for (int v = 0; v < 16; v++)
          mask[v] = ($urandom_range(0, 2) == 0) ? (9'd1 << $urandom_range(0, 8)) : 9'd0;
      end
    end
    @(posedge clk);
    #2 begin start = 1'b0; abort = 1'b0; rst = 1'b0; end
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
